// File: rtl/ram_sync_clr.sv
// Single-port synchronous RAM with a hardware clear sweep that zeroes every word after reset or a clr request.
// Define RAM_WRITE_FIRST_EN to make a read-during-write return din; the default build returns the pre-write word.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_CLEAR | sweeping: zero mem[cnt] each edge, busy=1, requests ignored
// ST_IDLE  | normal access: clr starts a sweep, otherwise read/write
module ram_sync_clr #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  wren,
    input  logic                  rden,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  rd_valid,
    output logic                  busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   dout_q, dout_d;
    logic                    rd_valid_q, rd_valid_d;
    logic                    busy_q, busy_d;

    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH-1:0]   mem_rdata;

    // No reset on the array: it is only ever initialised by the sweep.
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    assign mem_rdata = mem[address];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dout_d     = dout_q;
        rd_valid_d = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = address;
        mem_wdata  = din;

        case (state_q)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_wdata = '0;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                end
            end

            ST_IDLE: begin
                if (clr) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end else begin
                    mem_we = wren;
                    if (rden) begin
                        rd_valid_d = 1'b1;
`ifdef RAM_WRITE_FIRST_EN
                        dout_d = wren ? din : mem_rdata;
`else
                        dout_d = mem_rdata;
`endif
                    end
                end
            end

            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d == ST_CLEAR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_CLEAR;
            cnt_q      <= '0;
            dout_q     <= '0;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dout_q     <= dout_d;
            rd_valid_q <= rd_valid_d;
            busy_q     <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign dout     = dout_q;
    assign rd_valid = rd_valid_q;
    assign busy     = busy_q;

endmodule
